// File: rtl/ahbl_splitter.sv
// rtl/ahbl_splitter.sv - 1:N AHB-Lite splitter with address decode, data-phase tracking and
// a built-in two-cycle ERROR responder for unmapped transfers.
module ahbl_splitter #(
   parameter int                          N_PORTS   = 2,
   parameter int                          W_ADDR    = 32,
   parameter int                          W_DATA    = 32,
   parameter logic [N_PORTS*W_ADDR-1:0]   ADDR_MAP  = '0,
   parameter logic [N_PORTS*W_ADDR-1:0]   ADDR_MASK = '0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          src_hready,
   output logic                          src_hready_resp,
   output logic                          src_hresp,
   input  logic [W_ADDR-1:0]             src_haddr,
   input  logic                          src_hwrite,
   input  logic [1:0]                    src_htrans,
   input  logic [2:0]                    src_hsize,
   input  logic [2:0]                    src_hburst,
   input  logic [3:0]                    src_hprot,
   input  logic                          src_hmastlock,
   input  logic [W_DATA-1:0]             src_hwdata,
   output logic [W_DATA-1:0]             src_hrdata,
   output logic [N_PORTS-1:0]            dst_hready,
   input  logic [N_PORTS-1:0]            dst_hready_resp,
   input  logic [N_PORTS-1:0]            dst_hresp,
   output logic [N_PORTS*W_ADDR-1:0]     dst_haddr,
   output logic [N_PORTS-1:0]            dst_hwrite,
   output logic [N_PORTS*2-1:0]          dst_htrans,
   output logic [N_PORTS*3-1:0]          dst_hsize,
   output logic [N_PORTS*3-1:0]          dst_hburst,
   output logic [N_PORTS*4-1:0]          dst_hprot,
   output logic [N_PORTS-1:0]            dst_hmastlock,
   output logic [N_PORTS*W_DATA-1:0]     dst_hwdata,
   input  logic [N_PORTS*W_DATA-1:0]     dst_hrdata
);

   typedef enum logic [1:0] {ST_OK, ST_ERR1, ST_ERR2} state_t;

   state_t              state;
   logic                err_stall;
   logic                err_flag;
   logic [N_PORTS-1:0]  match;
   logic [N_PORTS-1:0]  sel;
   logic [N_PORTS-1:0]  dsel;
   logic                found;
   logic                active;
   logic                unmapped;

   assign active   = src_htrans[1];
   assign unmapped = src_hready && active && (match == '0);

   // Lowest-index match wins when decode windows overlap.
   always_comb begin
      match = '0;
      sel   = '0;
      found = 1'b0;
      for (int i = 0; i < N_PORTS; i++) begin
         match[i] = ((src_haddr & ADDR_MASK[i*W_ADDR +: W_ADDR]) == ADDR_MAP[i*W_ADDR +: W_ADDR]);
         if (match[i] && !found) begin
            sel[i] = 1'b1;
            found  = 1'b1;
         end
      end
   end

   genvar g;
   generate
      for (g = 0; g < N_PORTS; g++) begin : g_fanout
         assign dst_haddr[g*W_ADDR +: W_ADDR]  = src_haddr;
         assign dst_hwrite[g]                  = src_hwrite;
         assign dst_htrans[g*2 +: 2]           = (sel[g] && rst_n) ? src_htrans : 2'b00;
         assign dst_hsize[g*3 +: 3]            = src_hsize;
         assign dst_hburst[g*3 +: 3]           = src_hburst;
         assign dst_hprot[g*4 +: 4]            = src_hprot;
         assign dst_hmastlock[g]               = src_hmastlock;
         assign dst_hwdata[g*W_DATA +: W_DATA] = src_hwdata;
         assign dst_hready[g]                  = src_hready;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_OK;
         err_stall <= 1'b0;
         err_flag  <= 1'b0;
         dsel      <= '0;
      end else begin
         if (src_hready)
            dsel <= sel & {N_PORTS{active}};
         case (state)
            ST_ERR1: begin
               state     <= ST_ERR2;
               err_stall <= 1'b0;
               err_flag  <= 1'b1;
            end
            default: begin
               state     <= unmapped ? ST_ERR1 : ST_OK;
               err_stall <= unmapped;
               err_flag  <= unmapped;
            end
         endcase
      end
   end

   // Error responder overrides the slave mux; dsel is always zero while it runs.
   always_comb begin
      src_hready_resp = 1'b1;
      src_hresp       = 1'b0;
      src_hrdata      = '0;
      if (err_flag) begin
         src_hready_resp = !err_stall;
         src_hresp       = 1'b1;
      end else begin
         for (int i = 0; i < N_PORTS; i++) begin
            if (dsel[i]) begin
               src_hready_resp = dst_hready_resp[i];
               src_hresp       = dst_hresp[i];
               src_hrdata      = dst_hrdata[i*W_DATA +: W_DATA];
            end
         end
      end
   end

endmodule

// File: tb/tb_ahbl_splitter.sv
// tb/tb_ahbl_splitter.sv - directed and randomized bench for ahbl_splitter against a
// transaction-level model of decode, data-phase ownership and ERROR sequencing.
module tb_ahbl_splitter;

   localparam int N  = 2;
   localparam int WA = 32;
   localparam int WD = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            src_hready;
   logic            src_hready_resp;
   logic            src_hresp;
   logic [WA-1:0]   src_haddr;
   logic            src_hwrite;
   logic [1:0]      src_htrans;
   logic [2:0]      src_hsize;
   logic [2:0]      src_hburst;
   logic [3:0]      src_hprot;
   logic            src_hmastlock;
   logic [WD-1:0]   src_hwdata;
   logic [WD-1:0]   src_hrdata;
   logic [N-1:0]    dst_hready;
   logic [N-1:0]    dst_hready_resp;
   logic [N-1:0]    dst_hresp;
   logic [N*WA-1:0] dst_haddr;
   logic [N-1:0]    dst_hwrite;
   logic [N*2-1:0]  dst_htrans;
   logic [N*3-1:0]  dst_hsize;
   logic [N*3-1:0]  dst_hburst;
   logic [N*4-1:0]  dst_hprot;
   logic [N-1:0]    dst_hmastlock;
   logic [N*WD-1:0] dst_hwdata;
   logic [N*WD-1:0] dst_hrdata;

   always #5 clk = ~clk;

   // Single master: the bus HREADY is the splitter's own response.
   assign src_hready = src_hready_resp;

   ahbl_splitter #(
      .N_PORTS  (N),
      .W_ADDR   (WA),
      .W_DATA   (WD),
      .ADDR_MAP ({32'h2000_0000, 32'h0000_0000}),
      .ADDR_MASK({32'hF000_0000, 32'hF000_0000})
   ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .src_hready     (src_hready),
      .src_hready_resp(src_hready_resp),
      .src_hresp      (src_hresp),
      .src_haddr      (src_haddr),
      .src_hwrite     (src_hwrite),
      .src_htrans     (src_htrans),
      .src_hsize      (src_hsize),
      .src_hburst     (src_hburst),
      .src_hprot      (src_hprot),
      .src_hmastlock  (src_hmastlock),
      .src_hwdata     (src_hwdata),
      .src_hrdata     (src_hrdata),
      .dst_hready     (dst_hready),
      .dst_hready_resp(dst_hready_resp),
      .dst_hresp      (dst_hresp),
      .dst_haddr      (dst_haddr),
      .dst_hwrite     (dst_hwrite),
      .dst_htrans     (dst_htrans),
      .dst_hsize      (dst_hsize),
      .dst_hburst     (dst_hburst),
      .dst_hprot      (dst_hprot),
      .dst_hmastlock  (dst_hmastlock),
      .dst_hwdata     (dst_hwdata),
      .dst_hrdata     (dst_hrdata)
   );

   int   total = 0;
   int   bad   = 0;
   int   owner = -1;   // slave owning the data phase, -1 when none
   int   err   = 0;    // 0 none, 1 first ERROR cycle, 2 second ERROR cycle
   logic last_ready;
   logic last_resp;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int dec(input logic [31:0] a);
      logic [3:0] top;
      top = a[31:28];
      if (top == 4'h0) return 0;
      if (top == 4'h2) return 1;
      return -1;
   endfunction

   // Present one cycle of master/slave stimulus, check, then advance the model across the edge.
   task automatic step(input logic [31:0] addr, input logic [1:0] trans, input logic wr,
                       input logic [1:0] rdy, input logic [1:0] rsp,
                       input logic [31:0] rd0, input logic [31:0] rd1);
      logic [31:0] rds [2];
      logic [31:0] wd;
      logic [31:0] edata;
      logic [3:0]  etr;
      logic        er;
      logic        ep;
      int          d;
      wd              = $urandom;
      src_haddr       = addr;
      src_htrans      = trans;
      src_hwrite      = wr;
      src_hwdata      = wd;
      src_hsize       = 3'd2;
      src_hburst      = 3'd0;
      src_hprot       = 4'h3;
      src_hmastlock   = 1'b0;
      dst_hready_resp = rdy;
      dst_hresp       = rsp;
      dst_hrdata      = {rd1, rd0};
      #1;
      rds[0] = rd0;
      rds[1] = rd1;
      d      = dec(addr);
      if (err == 1) begin
         er = 1'b0; ep = 1'b1; edata = '0;
      end else if (err == 2) begin
         er = 1'b1; ep = 1'b1; edata = '0;
      end else if (owner >= 0) begin
         er = rdy[owner]; ep = rsp[owner]; edata = rds[owner];
      end else begin
         er = 1'b1; ep = 1'b0; edata = '0;
      end
      etr = '0;
      if (d >= 0) etr[d*2 +: 2] = trans;
      chk("hready_resp", {63'd0, src_hready_resp}, {63'd0, er});
      chk("hresp", {63'd0, src_hresp}, {63'd0, ep});
      chk("hrdata", {32'd0, src_hrdata}, {32'd0, edata});
      chk("dst_htrans", {60'd0, dst_htrans}, {60'd0, etr});
      chk("dsel", {62'd0, u_dut.dsel}, (owner < 0) ? 64'd0 : (64'd1 << owner));
      chk("dst_haddr1", {32'd0, dst_haddr[63:32]}, {32'd0, addr});
      chk("dst_hwdata0", {32'd0, dst_hwdata[31:0]}, {32'd0, wd});
      chk("dst_hready", {62'd0, dst_hready}, {62'd0, {2{er}}});
      last_ready = src_hready_resp;
      last_resp  = src_hresp;
      if (err == 1)
         err = 2;
      else if (er && trans[1] && d < 0)
         err = 1;
      else if (er)
         err = 0;
      if (er)
         owner = (trans[1] && d >= 0) ? d : -1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          lows;
      int          errs;
      logic [31:0] addr;
      rst_n           = 1'b0;
      src_haddr       = 32'h0000_0010;
      src_htrans      = 2'b10;
      src_hwrite      = 1'b0;
      src_hsize       = 3'd2;
      src_hburst      = 3'd0;
      src_hprot       = 4'h3;
      src_hmastlock   = 1'b0;
      src_hwdata      = '0;
      dst_hready_resp = 2'b11;
      dst_hresp       = 2'b00;
      dst_hrdata      = {32'h1111_1111, 32'h2222_2222};
      #1;
      chk("rst_hready_resp", {63'd0, src_hready_resp}, 64'd1);
      chk("rst_hresp", {63'd0, src_hresp}, 64'd0);
      chk("rst_hrdata", {32'd0, src_hrdata}, 64'd0);
      chk("rst_htrans", {60'd0, dst_htrans}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // 1: zero-wait read from slave0
      step(32'h0000_0010, 2'b10, 1'b0, 2'b11, 2'b00, 32'h0, 32'h0);
      step(32'h0000_0000, 2'b00, 1'b0, 2'b11, 2'b00, 32'hCAFE_F00D, 32'h5555_5555);

      // 2: write to slave1 with a three-cycle stall; the next address waits
      step(32'h2000_0004, 2'b10, 1'b1, 2'b11, 2'b00, 32'h0, 32'h0);
      lows = 0;
      for (int k = 0; k < 3; k++) begin
         step(32'h0000_0020, 2'b10, 1'b0, 2'b01, 2'b00, 32'h0, 32'h0);
         if (!last_ready) lows++;
      end
      step(32'h0000_0020, 2'b10, 1'b0, 2'b11, 2'b00, 32'h0, 32'h0);
      chk("stall_cycles", 64'(lows), 64'd3);
      step(32'h0000_0000, 2'b00, 1'b0, 2'b11, 2'b00, 32'h1234_5678, 32'h0);

      // 3: single unmapped transfer
      step(32'h4000_0000, 2'b10, 1'b0, 2'b11, 2'b00, 32'h0, 32'h0);
      step(32'h4000_0000, 2'b00, 1'b0, 2'b11, 2'b00, 32'h0, 32'h0);
      step(32'h4000_0000, 2'b00, 1'b0, 2'b11, 2'b00, 32'h0, 32'h0);
      step(32'h4000_0000, 2'b00, 1'b0, 2'b11, 2'b00, 32'h0, 32'h0);

      // 4: back-to-back across slaves
      step(32'h0000_0000, 2'b10, 1'b0, 2'b11, 2'b00, 32'h0, 32'h0);
      step(32'h2000_0000, 2'b10, 1'b0, 2'b11, 2'b00, 32'hAAAA_0001, 32'hBBBB_0001);
      step(32'h0000_0008, 2'b10, 1'b0, 2'b11, 2'b00, 32'hAAAA_0002, 32'hBBBB_0002);
      step(32'h0000_0000, 2'b00, 1'b0, 2'b11, 2'b00, 32'hAAAA_0003, 32'hBBBB_0003);

      // 5: second unmapped transfer issued during ERR2
      step(32'h4000_0000, 2'b10, 1'b0, 2'b11, 2'b00, 32'h0, 32'h0);
      errs = 0;
      step(32'h5000_0000, 2'b00, 1'b0, 2'b11, 2'b00, 32'h0, 32'h0);
      if (last_resp) errs++;
      step(32'h5000_0000, 2'b10, 1'b0, 2'b11, 2'b00, 32'h0, 32'h0);
      if (last_resp) errs++;
      step(32'h5000_0000, 2'b00, 1'b0, 2'b11, 2'b00, 32'h0, 32'h0);
      if (last_resp) errs++;
      step(32'h5000_0000, 2'b00, 1'b0, 2'b11, 2'b00, 32'h0, 32'h0);
      if (last_resp) errs++;
      step(32'h0000_0000, 2'b00, 1'b0, 2'b11, 2'b00, 32'h0, 32'h0);
      if (last_resp) errs++;
      chk("err_cycles", 64'(errs), 64'd4);

      // 6: asynchronous reset while slave1 stalls
      step(32'h2000_0000, 2'b10, 1'b0, 2'b11, 2'b00, 32'h0, 32'h0);
      step(32'h0000_0000, 2'b00, 1'b0, 2'b01, 2'b00, 32'h0, 32'h0);
      dst_hready_resp = 2'b01;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_hready_resp", {63'd0, src_hready_resp}, 64'd1);
      chk("arst_hresp", {63'd0, src_hresp}, 64'd0);
      chk("arst_dsel", {62'd0, u_dut.dsel}, 64'd0);
      chk("arst_hrdata", {32'd0, src_hrdata}, 64'd0);
      owner = -1;
      err   = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(32'h0000_0000, 2'b00, 1'b0, 2'b01, 2'b00, 32'h0, 32'h0);
      step(32'h0000_0000, 2'b00, 1'b0, 2'b11, 2'b00, 32'h0, 32'h0);

      // Randomized traffic with random slave stalls and responses
      for (int k = 0; k < 400; k++) begin
         case ($urandom_range(0, 3))
            0:       addr = {4'h0, 28'($urandom)};
            1:       addr = {4'h2, 28'($urandom)};
            2:       addr = {4'h4, 28'($urandom)};
            default: addr = $urandom;
         endcase
         step(addr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)},
              {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)},
              $urandom, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ahbl_splitter.md
Name: ahbl_splitter

Overview:
- 1:N AHB-Lite splitter: one upstream master port fanned out to N downstream slave ports by address decode.
- It is the counterpart of the N:1 arbiter, and sits between an arbiter output (or a single master) and a group of slaves.
- It tracks which slave owns the current data phase.
- It generates the two-cycle AHB-Lite ERROR response itself for transfers that decode to no slave.

Parameters:
- N_PORTS, 2, number of downstream slave ports.
- W_ADDR, 32, address width.
- W_DATA, 32, data width.
- ADDR_MAP, {N_PORTS*W_ADDR{1'b0}}, concatenated base addresses; port i occupies bits [i*W_ADDR +: W_ADDR].
- ADDR_MASK, {N_PORTS*W_ADDR{1'b0}}, concatenated decode masks; port i matches when (haddr & mask_i) == map_i.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous and active-low
- src_hready  in  1  upstream HREADY; broadcast to all slaves
- src_hready_resp  out  1  HREADYOUT to the upstream master
- src_hresp  out  1  HRESP to the upstream master
- src_haddr  in  W_ADDR  address
- src_hwrite  in  1  write flag
- src_htrans  in  2  transfer type
- src_hsize  in  3  transfer size
- src_hburst  in  3  burst type
- src_hprot  in  4  protection
- src_hmastlock  in  1  locked transfer
- src_hwdata  in  W_DATA  write data
- src_hrdata  out  W_DATA  read data
- dst_hready  out  N_PORTS  HREADY to each slave
- dst_hready_resp  in  N_PORTS  HREADYOUT from each slave
- dst_hresp  in  N_PORTS  HRESP from each slave
- dst_haddr  out  N_PORTS*W_ADDR  address, broadcast
- dst_hwrite  out  N_PORTS  write flag, broadcast
- dst_htrans  out  N_PORTS*2  transfer type; gated per port
- dst_hsize  out  N_PORTS*3  transfer size, broadcast
- dst_hburst  out  N_PORTS*3  burst type, broadcast
- dst_hprot  out  N_PORTS*4  protection, broadcast
- dst_hmastlock  out  N_PORTS  locked transfer, broadcast
- dst_hwdata  out  N_PORTS*W_DATA  write data, broadcast
- dst_hrdata  in  N_PORTS*W_DATA  read data from each slave

Behaviour:
- **Decode (combinational)**
  - match[i] = ((src_haddr & ADDR_MASK_i) == ADDR_MAP_i).
  - Select is one-hot, lowest index wins when several ports match.
  - A transfer is active when src_htrans[1] = 1 (NSEQ/SEQ). IDLE and BUSY are never forwarded as active.
- **Address-phase fan-out (no added latency)**
  - haddr, hwrite, hsize, hburst, hprot, hmastlock and hwdata are replicated to every port.
  - dst_htrans for port i = src_htrans if sel[i], else 2'b00.
  - dst_hready = {N_PORTS{src_hready}}.
- **Data-phase tracking register dsel (N_PORTS bits, one-hot or zero)**
  - When src_hready = 1: dsel <= sel & {N{src_htrans[1]}}.
  - Otherwise dsel holds its value.
- **Error FSM: states OK, ERR1, ERR2**
  - OK -> ERR1 when src_hready = 1, src_htrans[1] = 1 and no port matches.
  - ERR1 -> ERR2 unconditionally.
  - ERR2 follows the same entry rule as OK: it goes to ERR1 on another unmapped active transfer, otherwise to OK.
  - ERR1 outputs src_hready_resp = 0, src_hresp = 1. ERR2 outputs src_hready_resp = 1, src_hresp = 1.
- **Response mux**
  - When dsel is non-zero: src_hready_resp, src_hresp and src_hrdata come from the port selected by dsel.
  - When dsel is zero and the state is OK: src_hready_resp = 1, src_hresp = 0, src_hrdata = 0.
- **Reset**
  - dsel = 0 and state = OK.
  - Hence src_hready_resp = 1, src_hresp = 0, src_hrdata = 0.
  - All dst_htrans = 0. Other dst_* signals follow src_* combinationally.
  - Reset mid-transfer abandons the data phase with no ERROR emitted.
- **Boundaries**
  - A slave stall holds dsel; the next address is latched only on src_hready.
  - If the master drops to IDLE during ERR2, no transfer is forwarded.
  - Back-to-back transfers to different slaves switch dsel on the same edge the new address phase is accepted.

Test Plan:
- Configuration for all scenarios: N_PORTS=2, port0 map 0x0000_0000 mask 0xF000_0000, port1 map 0x2000_0000 mask 0xF000_0000.
1. NSEQ read 0x0000_0010, slave0 returns 0xCAFEF00D with zero wait -> dst_htrans port0=2, port1=0; src_hrdata = 0xCAFEF00D one cycle later, src_hresp = 0.
2. Write to 0x2000_0004, slave1 holds hready_resp=0 for 3 cycles -> src_hready_resp low exactly 3 cycles; dsel stays 2'b10; next address not forwarded as accepted until ready.
3. NSEQ to 0x4000_0000 (unmapped) -> no port sees active htrans; src_hready_resp/src_hresp = 0/1 then 1/1, then OK.
4. Back-to-back transfers 0x0000_0000, 0x2000_0000, 0x0000_0008 with zero wait -> dsel sequence 01, 10, 01; each hrdata taken from the correct port.
5. Unmapped transfer followed immediately by another unmapped transfer during ERR2 -> two full ERROR responses, 4 cycles total.
6. Assert rst_n low while slave1 stalls -> src_hready_resp = 1, src_hresp = 0, dsel = 0 asynchronously; clean IDLE after release.
